uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Parametrised UART transmitter with an input FIFO, a programmable baud prescaler, optional parity and one or two stop bits. It accepts parallel words through a valid/ready handshake, queues them, and serialises each one LSB-first onto `S_DATA`. Queued frames go out back-to-back. It sits between the system-side producer and the TX pin, and replaces the single-word, one-clock-per-bit transmitter.

## Interface
- `P_DATA_WIDTH`, 8: data bits per frame (5..9).
- `FIFO_DEPTH`, 4: word capacity of the input FIFO (power of two, >= 2).
- `PRESCALE_WIDTH`, 8: width of the `PRESCALE` input.

- `CLK`  in  1  system clock; all logic on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `P_DATA`  in  P_DATA_WIDTH  word to transmit.
- `Data_Valid`  in  1  `P_DATA` is valid this cycle.
- `Data_Ready`  out  1  FIFO can accept a word (not full).
- `PAR_EN`  in  1  1 = append a parity bit.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `STOP2`  in  1  1 = two stop bits, 0 = one stop bit.
- `PRESCALE`  in  PRESCALE_WIDTH  bit period minus one, in `CLK` cycles.
- `S_DATA`  out  1  serial line; idles high.
- `busy`  out  1  a frame is in progress.
- `fifo_count`  out  $clog2(FIFO_DEPTH+1)  number of words queued.

## Operation
- **Write:** a word is accepted on a rising edge where `Data_Valid && Data_Ready`.
  - `Data_Ready = (fifo_count != FIFO_DEPTH)`.
  - When full, the write is refused even if a pop happens in the same cycle.
  - Refused data is dropped without any error indication.
- **Simultaneous push and pop:** when not full, both happen and `fifo_count` is unchanged.
- **FSM states:** IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is non-empty. On that edge: pop the head word into the shift register, and latch `PAR_EN`, `PAR_TYP`, `STOP2` and `PRESCALE` into frame registers.
  - START -> DATA after one bit period.
  - DATA sends bit 0 first and shifts right. After P_DATA_WIDTH bit periods it goes to PARITY if the latched `PAR_EN` is set, otherwise to STOP.
  - PARITY -> STOP after one bit period.
  - STOP lasts one bit period, or two if the latched `STOP2` is set. It then goes to START (FIFO non-empty, popping as from IDLE) or to IDLE.
- **Configuration:** input changes during a frame have no effect until the next frame starts.
- **Bit period:** the latched `PRESCALE` + 1 cycles. A down-counter reloads at each bit boundary. `PRESCALE` = 0 gives one bit per clock.
- **Parity:** parity bit = XOR of the data bits when `PAR_TYP` = 0; the inverse of that XOR when `PAR_TYP` = 1.
- **`S_DATA` and `busy`:** both are registered. `S_DATA` is 0 in START, the current LSB in DATA, the parity bit in PARITY, and 1 in STOP and IDLE. `busy` = (state != IDLE).
- **Reset:** `RST` is sampled on the rising edge and overrides everything.
  - Outputs after reset: `S_DATA` = 1, `busy` = 0, `Data_Ready` = 1, `fifo_count` = 0.
  - FIFO pointers, prescale counter and bit counter are cleared; the FSM returns to IDLE.
  - Reset mid-frame aborts the frame: the line is high from the next cycle and queued words are discarded.

## Timing
- Write-to-line latency into an empty, idle block is one cycle.
  - Word accepted at edge N: `fifo_count` = 1 after N.
  - At edge N+1 the word is popped, so `fifo_count` = 0, `S_DATA` = 0 and `busy` = 1.
- Frame length in cycles = (PRESCALE+1) × (1 + P_DATA_WIDTH + PAR_EN + 1 + STOP2).
- Back-to-back frames have zero idle cycles. The next start bit follows the last stop-bit cycle directly, and `busy` stays high.
- `busy` falls on the edge after the last stop-bit cycle, and only if the FIFO is empty.
- `Data_Ready` and `fifo_count` update on the edge of the push or pop, with no combinational path from `Data_Valid`.

## Test plan
1. **Single word, no parity:** `RST` pulse; PRESCALE = 0, PAR_EN = 0, STOP2 = 0; write 0x5A.
   -> `S_DATA` per cycle reads 0, 0,1,0,1,1,0,1,0, 1, then idle 1. `busy` is high for exactly 10 cycles.
2. **Parity, stretched bits, two stop bits:** PRESCALE = 3, PAR_EN = 1, PAR_TYP = 1, STOP2 = 1; write 0x6B.
   -> Each bit holds for 4 cycles. Data reads 1,1,0,1,0,1,1,0, the parity bit is 0, and there are 2 stop bits. The frame is 48 cycles.
   -> Repeat with PAR_TYP = 0 and 0x5A: parity bit 0. With PAR_TYP = 1: parity bit 1.
3. **FIFO full and back-to-back frames:** FIFO_DEPTH = 4, PRESCALE = 15; six writes on consecutive cycles.
   -> The first five are accepted and the sixth is refused. `Data_Ready` is low and `fifo_count` = 4 after the fifth.
   -> Five frames go out with no gap, and `busy` is continuously high.
4. **Mid-frame configuration change:** start a frame with PAR_EN = 0, then set PAR_EN = 1 and PRESCALE = 7 during DATA.
   -> The current frame has no parity and keeps its original bit period. The next queued frame uses the new settings.
5. **Reset mid-frame:** `RST` high for one cycle during the DATA of the second of three queued words.
   -> After the next edge: `S_DATA` = 1, `busy` = 0, `fifo_count` = 0 and `Data_Ready` = 1. Nothing further is transmitted.
6. **Simultaneous push and pop:** a write lands on the same edge as the pop at the end of a frame.
   -> `fifo_count` is unchanged and the frames stay gapless.

Source files
------------

// File: rtl/uart_tx_fifo_if.sv
// Producer-side word handshake into uart_tx_fifo: the producer drives the word
// and its valid flag, and the transmitter returns ready while its FIFO has room.
interface uart_tx_fifo_if #(
   parameter int P_DATA_WIDTH = 8
) ();
   logic [P_DATA_WIDTH-1:0] P_DATA;
   logic                    Data_Valid;
   logic                    Data_Ready;

   modport master (output P_DATA, output Data_Valid, input Data_Ready);
   modport slave  (input P_DATA, input Data_Valid, output Data_Ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small word FIFO. Frames are serialised LSB-first
// with a programmable bit period, optional parity and one or two stop bits.
module uart_tx_fifo #(
   parameter int P_DATA_WIDTH   = 8,
   parameter int FIFO_DEPTH     = 4,
   parameter int PRESCALE_WIDTH = 8
) (
   input  logic                             CLK,
   input  logic                             RST,
   uart_tx_fifo_if.slave                    in_if,
   input  logic                             PAR_EN,
   input  logic                             PAR_TYP,
   input  logic                             STOP2,
   input  logic [PRESCALE_WIDTH-1:0]        PRESCALE,
   output logic                             S_DATA,
   output logic                             busy,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int BIT_W = $clog2(P_DATA_WIDTH);
   localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(FIFO_DEPTH);
   localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(P_DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } state_t;

   // Even parity is the XOR of the data bits; odd parity is its inverse.
   function automatic logic parity_bit(input logic [P_DATA_WIDTH-1:0] data,
                                       input logic odd);
      parity_bit = (^data) ^ odd;
   endfunction

   logic [P_DATA_WIDTH-1:0]   mem_r [FIFO_DEPTH];
   logic [PTR_W-1:0]          wr_ptr_r;
   logic [PTR_W-1:0]          rd_ptr_r;
   logic [CNT_W-1:0]          count_r;
   logic                      ready_r;
   state_t                    state_r;
   logic [PRESCALE_WIDTH-1:0] pre_cnt_r;
   logic [PRESCALE_WIDTH-1:0] pre_r;
   logic [BIT_W-1:0]          bit_cnt_r;
   logic [P_DATA_WIDTH-1:0]   shift_r;
   logic                      par_bit_r;
   logic                      par_en_r;
   logic                      stop2_r;
   logic                      s_data_r;
   logic                      busy_r;

   logic                      push_s;
   logic                      pop_s;
   logic                      bit_end_s;
   state_t                    state_nxt_s;
   logic [PRESCALE_WIDTH-1:0] pre_cnt_nxt_s;
   logic [BIT_W-1:0]          bit_cnt_nxt_s;
   logic [P_DATA_WIDTH-1:0]   shift_nxt_s;
   logic [CNT_W-1:0]          count_nxt_s;
   logic                      line_nxt_s;

   assign push_s    = in_if.Data_Valid && ready_r;
   assign bit_end_s = (pre_cnt_r == '0);

   // Frame sequencing: next state, bit timing, shifting and the FIFO pop.
   always_comb begin
      state_nxt_s   = state_r;
      pop_s         = 1'b0;
      bit_cnt_nxt_s = bit_cnt_r;
      shift_nxt_s   = shift_r;
      pre_cnt_nxt_s = bit_end_s ? pre_r : (pre_cnt_r - PRESCALE_WIDTH'(1));
      case (state_r)
         ST_IDLE: begin
            if (count_r != '0) begin
               pop_s         = 1'b1;
               state_nxt_s   = ST_START;
               pre_cnt_nxt_s = PRESCALE;
               shift_nxt_s   = mem_r[rd_ptr_r];
            end else begin
               state_nxt_s   = ST_IDLE;
               pre_cnt_nxt_s = pre_cnt_r;
            end
         end
         ST_START: begin
            if (bit_end_s) begin
               state_nxt_s   = ST_DATA;
               bit_cnt_nxt_s = '0;
            end else begin
               state_nxt_s   = ST_START;
            end
         end
         ST_DATA: begin
            if (bit_end_s) begin
               if (bit_cnt_r == LAST_BIT) begin
                  state_nxt_s   = par_en_r ? ST_PARITY : ST_STOP;
                  bit_cnt_nxt_s = '0;
               end else begin
                  bit_cnt_nxt_s = bit_cnt_r + BIT_W'(1);
                  shift_nxt_s   = shift_r >> 1'b1;
               end
            end else begin
               state_nxt_s = ST_DATA;
            end
         end
         ST_PARITY: begin
            if (bit_end_s) begin
               state_nxt_s   = ST_STOP;
               bit_cnt_nxt_s = '0;
            end else begin
               state_nxt_s   = ST_PARITY;
            end
         end
         ST_STOP: begin
            // bit_cnt_r counts stop bits here; a second one is inserted only when latched.
            if (bit_end_s) begin
               if (stop2_r && (bit_cnt_r == '0)) begin
                  bit_cnt_nxt_s = BIT_W'(1);
               end else if (count_r != '0) begin
                  pop_s         = 1'b1;
                  state_nxt_s   = ST_START;
                  pre_cnt_nxt_s = PRESCALE;
                  shift_nxt_s   = mem_r[rd_ptr_r];
               end else begin
                  state_nxt_s   = ST_IDLE;
               end
            end else begin
               state_nxt_s = ST_STOP;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Line level for the state being entered, so S_DATA can be registered.
   always_comb begin
      line_nxt_s = 1'b1;
      case (state_nxt_s)
         ST_IDLE:   line_nxt_s = 1'b1;
         ST_START:  line_nxt_s = 1'b0;
         ST_DATA:   line_nxt_s = shift_nxt_s[0];
         ST_PARITY: line_nxt_s = par_bit_r;
         ST_STOP:   line_nxt_s = 1'b1;
         default:   line_nxt_s = 1'b1;
      endcase
   end

   // FIFO occupancy after this cycle's push and pop.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + CNT_W'(1);
         2'b01:   count_nxt_s = count_r - CNT_W'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Control, frame and output registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r   <= ST_IDLE;
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         ready_r   <= 1'b1;
         pre_cnt_r <= '0;
         pre_r     <= '0;
         bit_cnt_r <= '0;
         shift_r   <= '0;
         par_bit_r <= 1'b0;
         par_en_r  <= 1'b0;
         stop2_r   <= 1'b0;
         s_data_r  <= 1'b1;
         busy_r    <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         count_r   <= count_nxt_s;
         ready_r   <= (count_nxt_s != FULL_COUNT);
         pre_cnt_r <= pre_cnt_nxt_s;
         bit_cnt_r <= bit_cnt_nxt_s;
         shift_r   <= shift_nxt_s;
         s_data_r  <= line_nxt_s;
         busy_r    <= (state_nxt_s != ST_IDLE);
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_W'(1);
         end
         if (pop_s) begin
            rd_ptr_r  <= rd_ptr_r + PTR_W'(1);
            pre_r     <= PRESCALE;
            par_en_r  <= PAR_EN;
            stop2_r   <= STOP2;
            par_bit_r <= parity_bit(mem_r[rd_ptr_r], PAR_TYP);
         end
      end
   end

   // FIFO storage; contents need no reset because the pointers are cleared.
   always_ff @(posedge CLK) begin
      if (!RST && push_s) begin
         mem_r[wr_ptr_r] <= in_if.P_DATA;
      end
   end

   assign S_DATA           = s_data_r;
   assign busy             = busy_r;
   assign fifo_count       = count_r;
   assign in_if.Data_Ready = ready_r;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomised and directed bench for uart_tx_fifo against a word-queue and
// frame-waveform reference model.
module tb_uart_tx_fifo;

   localparam int W     = 8;
   localparam int DEPTH = 4;
   localparam int PW    = 8;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk_s = 1'b0;
   logic          rst_s;
   logic          par_en_s;
   logic          par_typ_s;
   logic          stop2_s;
   logic [PW-1:0] pre_s;
   logic          s_data_s;
   logic          busy_s;
   logic [CW-1:0] count_s;

   uart_tx_fifo_if #(.P_DATA_WIDTH(W)) bus ();

   uart_tx_fifo #(
      .P_DATA_WIDTH(W), .FIFO_DEPTH(DEPTH), .PRESCALE_WIDTH(PW)
   ) dut (
      .CLK(clk_s), .RST(rst_s), .in_if(bus.slave),
      .PAR_EN(par_en_s), .PAR_TYP(par_typ_s), .STOP2(stop2_s),
      .PRESCALE(pre_s), .S_DATA(s_data_s), .busy(busy_s), .fifo_count(count_s)
   );

   always #5 clk_s = ~clk_s;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model: queued words plus the remaining line samples of the frame in flight.
   logic [W-1:0] word_q [$];
   bit           line_q [$];
   int           exp_line = 1;
   int           exp_busy = 0;
   int           busy_run = 0;
   int           max_run  = 0;

   task automatic check_value(input string tag, input int obs, input int exp);
      n_cmp++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   task automatic build_frame(input logic [W-1:0] word);
      bit bits [$];
      int reps;
      reps = int'(pre_s) + 1;
      bits.push_back(1'b0);
      for (int i = 0; i < W; i++) bits.push_back(word[i]);
      if (par_en_s) bits.push_back(bit'(($countones(word) % 2) ^ int'(par_typ_s)));
      bits.push_back(1'b1);
      if (stop2_s) bits.push_back(1'b1);
      foreach (bits[i]) begin
         for (int r = 0; r < reps; r++) line_q.push_back(bits[i]);
      end
   endtask

   // One clock: advance the model on the inputs now applied, then compare after the edge.
   task automatic step();
      int pre_size;
      bit accept;
      pre_size = word_q.size();
      accept   = bus.Data_Valid && (pre_size != DEPTH);
      if (rst_s) begin
         word_q.delete();
         line_q.delete();
         exp_line = 1;
         exp_busy = 0;
      end else begin
         if (line_q.size() == 0 && pre_size > 0) build_frame(word_q.pop_front());
         if (accept) word_q.push_back(bus.P_DATA);
         if (line_q.size() > 0) begin
            exp_line = int'(line_q.pop_front());
            exp_busy = 1;
         end else begin
            exp_line = 1;
            exp_busy = 0;
         end
      end
      @(posedge clk_s);
      #1;
      check_value("s_data", int'(s_data_s), exp_line);
      check_value("busy", int'(busy_s), exp_busy);
      check_value("fifo_count", int'(count_s), word_q.size());
      check_value("data_ready", int'(bus.Data_Ready), int'(word_q.size() != DEPTH));
      if (busy_s) busy_run++;
      else busy_run = 0;
      if (busy_run > max_run) max_run = busy_run;
   endtask

   task automatic write_word(input logic [W-1:0] word);
      bus.Data_Valid = 1'b1;
      bus.P_DATA     = word;
      step();
      bus.Data_Valid = 1'b0;
   endtask

   task automatic drain();
      for (int g = 0; g < 20000 && (exp_busy != 0 || word_q.size() != 0); g++) step();
      check_value("drain_idle", int'(busy_s), 0);
   endtask

   task automatic clear_run();
      busy_run = 0;
      max_run  = 0;
   endtask

   initial begin
      int lows;
      int exp_cnt;
      bit found;
      rst_s = 1'b1; bus.Data_Valid = 1'b0; bus.P_DATA = '0;
      par_en_s = 1'b0; par_typ_s = 1'b0; stop2_s = 1'b0; pre_s = '0;
      step(); step();
      rst_s = 1'b0;
      step();

      // Single word, no parity, one clock per bit.
      clear_run();
      write_word(8'h5A);
      drain();
      check_value("t1_frame_len", max_run, 10);

      // Parity with stretched bits and two stop bits.
      pre_s = 8'd3; par_en_s = 1'b1; par_typ_s = 1'b1; stop2_s = 1'b1;
      clear_run(); write_word(8'h6B); drain();
      check_value("t2_frame_len_6b", max_run, 48);
      par_typ_s = 1'b0;
      clear_run(); write_word(8'h5A); drain();
      check_value("t2_frame_len_even", max_run, 48);
      par_typ_s = 1'b1;
      clear_run(); write_word(8'h5A); drain();
      check_value("t2_frame_len_odd", max_run, 48);

      // FIFO full with six back-to-back writes; five gapless frames.
      pre_s = 8'd15; par_en_s = 1'b0; stop2_s = 1'b0;
      clear_run();
      for (int i = 0; i < 6; i++) begin
         bus.Data_Valid = 1'b1;
         bus.P_DATA     = W'($urandom);
         step();
         if (i == 4) begin
            check_value("t3_ready_full", int'(bus.Data_Ready), 0);
            check_value("t3_count_full", int'(count_s), 4);
         end
      end
      bus.Data_Valid = 1'b0;
      drain();
      check_value("t3_gapless_run", max_run, 5 * 16 * 10);

      // Configuration change during DATA only affects the following frame.
      pre_s = 8'd1; par_en_s = 1'b0;
      clear_run();
      bus.Data_Valid = 1'b1; bus.P_DATA = 8'h3C; step();
      bus.P_DATA = 8'hC3; step();
      bus.Data_Valid = 1'b0;
      repeat (6) step();
      par_en_s = 1'b1; pre_s = 8'd7;
      drain();
      check_value("t4_run", max_run, 2 * 10 + 8 * 11);

      // Reset in the middle of the second of three queued frames.
      pre_s = 8'd3; par_en_s = 1'b0; stop2_s = 1'b0;
      bus.Data_Valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         bus.P_DATA = W'($urandom);
         step();
      end
      bus.Data_Valid = 1'b0;
      repeat (50) step();
      rst_s = 1'b1; step(); rst_s = 1'b0;
      check_value("t5_line_high", int'(s_data_s), 1);
      check_value("t5_not_busy", int'(busy_s), 0);
      check_value("t5_count_zero", int'(count_s), 0);
      check_value("t5_ready", int'(bus.Data_Ready), 1);
      clear_run();
      lows = 0;
      repeat (60) begin
         step();
         if (!s_data_s) lows++;
      end
      check_value("t5_no_tx_low", lows, 0);
      check_value("t5_no_tx_busy", max_run, 0);

      // Push landing on the pop edge at a frame boundary.
      pre_s = 8'd0;
      clear_run();
      bus.Data_Valid = 1'b1; bus.P_DATA = 8'h81; step();
      bus.P_DATA = 8'h7E; step();
      bus.Data_Valid = 1'b0;
      found = 1'b0;
      for (int g = 0; g < 50 && !found; g++) begin
         if (line_q.size() == 0 && exp_busy != 0 && word_q.size() > 0) found = 1'b1;
         else step();
      end
      check_value("t6_boundary_found", int'(found), 1);
      exp_cnt = word_q.size();
      bus.Data_Valid = 1'b1; bus.P_DATA = 8'h33; step();
      bus.Data_Valid = 1'b0;
      check_value("t6_count_kept", int'(count_s), exp_cnt);
      drain();
      check_value("t6_gapless_run", max_run, 30);

      // Random traffic, configuration changes and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         bus.Data_Valid = ($urandom_range(0, 2) == 0);
         bus.P_DATA     = W'($urandom);
         if ($urandom_range(0, 19) == 0) begin
            par_en_s  = 1'($urandom_range(0, 1));
            par_typ_s = 1'($urandom_range(0, 1));
            stop2_s   = 1'($urandom_range(0, 1));
            pre_s     = PW'($urandom_range(0, 3));
         end
         rst_s = ($urandom_range(0, 599) == 0);
         step();
      end
      rst_s = 1'b0;
      bus.Data_Valid = 1'b0;
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
